nes_pad_responder: RTL

- Emulates the NES controller side of the serial pad protocol: the 4021-style shift register the console reads.
- Accepts the console's latch and clock lines, snapshots an 8-bit button vector, and shifts it out on the data line in the order A, B, Select, Start, Up, Down, Left, Right.
- Used as a bench partner for the receiver and to let an FPGA pose as a controller to real hardware.

---
 rtl/nes_pad_if.sv | 24 ++
 rtl/nes_pad_responder.sv | 126 ++++++++++++
 2 files changed

// File: rtl/nes_pad_if.sv
// Pad-side signal bundle between an NES console (or bench) and the pad responder.
// master = console side, slave = pad responder.
interface nes_pad_if #(
  parameter int FRAME_CNT_W = 16
);
  logic [7:0]             buttons;
  logic                   latch_in;
  logic                   pulse_in;
  logic                   data_out;
  logic [3:0]             bit_index;
  logic                   frame_done;
  logic                   overrun;
  logic [FRAME_CNT_W-1:0] frame_count;

  modport master (
    output buttons, latch_in, pulse_in,
    input  data_out, bit_index, frame_done, overrun, frame_count
  );

  modport slave (
    input  buttons, latch_in, pulse_in,
    output data_out, bit_index, frame_done, overrun, frame_count
  );
endinterface

// File: rtl/nes_pad_responder.sv
// Controller-side emulation of the NES 4021 serial pad: synchronises the console's
// latch/clock lines and shifts an active-low button snapshot out A-first.
module nes_pad_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_CNT_W = 16
) (
  input logic      clk,
  input logic      reset,
  nes_pad_if.slave pad
);
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} state_t;

  localparam logic [FRAME_CNT_W-1:0] CNT_ONE = {{(FRAME_CNT_W-1){1'b0}}, 1'b1};

  state_t                 state_r, state_s;
  logic [SYNC_STAGES-1:0] latch_sync_r, pulse_sync_r;
  logic                   latch_hist_r, pulse_hist_r;
  logic [7:0]             shreg_r, shreg_s;
  logic [3:0]             idx_r, idx_s;
  logic                   data_r, data_s;
  logic                   done_r, done_s;
  logic                   ovr_r, ovr_s;
  logic [FRAME_CNT_W-1:0] cnt_r, cnt_s;
  logic                   latch_s, latch_rise_s, pulse_rise_s;

  // Synchronizer chains plus one history flop per console line
  always_ff @(posedge clk) begin
    if (!reset) begin
      latch_sync_r <= {SYNC_STAGES{1'b0}};
      pulse_sync_r <= {SYNC_STAGES{1'b0}};
      latch_hist_r <= 1'b0;
      pulse_hist_r <= 1'b0;
    end else begin
      latch_sync_r <= {latch_sync_r[SYNC_STAGES-2:0], pad.latch_in};
      pulse_sync_r <= {pulse_sync_r[SYNC_STAGES-2:0], pad.pulse_in};
      latch_hist_r <= latch_sync_r[SYNC_STAGES-1];
      pulse_hist_r <= pulse_sync_r[SYNC_STAGES-1];
    end
  end

  assign latch_s      = latch_sync_r[SYNC_STAGES-1];
  assign latch_rise_s = latch_sync_r[SYNC_STAGES-1] & ~latch_hist_r;
  assign pulse_rise_s = pulse_sync_r[SYNC_STAGES-1] & ~pulse_hist_r;

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      shreg_r <= 8'h00;
      idx_r   <= 4'd0;
      data_r  <= 1'b1;
      done_r  <= 1'b0;
      ovr_r   <= 1'b0;
      cnt_r   <= {FRAME_CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      shreg_r <= shreg_s;
      idx_r   <= idx_s;
      data_r  <= data_s;
      done_r  <= done_s;
      ovr_r   <= ovr_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic; a high latch overrides any pulse activity in every state
  always_comb begin
    state_s = state_r;
    shreg_s = shreg_r;
    idx_s   = idx_r;
    done_s  = 1'b0;
    ovr_s   = ovr_r;
    cnt_s   = cnt_r;
    data_s  = 1'b1;
    if (latch_s) begin
      state_s = ST_LOAD;
      shreg_s = ~pad.buttons;
      idx_s   = 4'd0;
      if (latch_rise_s) begin
        ovr_s = 1'b0;
      end else begin
        ovr_s = ovr_r;
      end
    end else begin
      case (state_r)
        ST_IDLE:  state_s = ST_IDLE;
        ST_LOAD:  state_s = ST_SHIFT;
        ST_SHIFT: begin
          if (pulse_rise_s) begin
            shreg_s = {1'b0, shreg_r[7:1]};
            idx_s   = idx_r + 4'd1;
            if (idx_r == 4'd7) begin
              done_s  = 1'b1;
              cnt_s   = cnt_r + CNT_ONE;
              state_s = ST_DONE;
            end else begin
              state_s = ST_SHIFT;
            end
          end else begin
            state_s = ST_SHIFT;
          end
        end
        ST_DONE: begin
          if (pulse_rise_s) begin
            ovr_s = 1'b1;
          end else begin
            ovr_s = ovr_r;
          end
        end
        default: state_s = ST_IDLE;
      endcase
    end
    // Exhausted pad drives 0, as a real 4021 with its serial input grounded
    case (state_s)
      ST_IDLE: data_s = 1'b1;
      ST_DONE: data_s = 1'b0;
      default: data_s = shreg_s[0];
    endcase
  end

  assign pad.data_out    = data_r;
  assign pad.bit_index   = idx_r;
  assign pad.frame_done  = done_r;
  assign pad.overrun     = ovr_r;
  assign pad.frame_count = cnt_r;
endmodule
